// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op encodings presented on the op port
//   - FSM state encoding used by mdu_hilo
//   - small helper to classify divide ops
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo_divider.sv
// mdu_divider: iterative restoring radix-2 divider on unsigned magnitudes.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   i_start        load operands; the first quotient bit is resolved on this edge
//   i_dividend     dividend magnitude
//   i_divisor      divisor magnitude (caller guarantees non-zero)
//   o_last         high in the cycle whose edge produces the final quotient bit
//   o_quo, o_rem   quotient / remainder, valid once the counter has drained
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_rem, r_quo, r_dsr;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_src_rem, w_src_quo, w_src_dsr;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_nrem, w_nquo;

  // One restoring step. The quotient register doubles as the dividend shift
  // register: its MSB feeds the partial remainder, the new bit enters at LSB.
  always_comb begin
    w_src_rem = i_start ? '0         : r_rem;
    w_src_quo = i_start ? i_dividend : r_quo;
    w_src_dsr = i_start ? i_divisor  : r_dsr;
    w_shift   = {w_src_rem, w_src_quo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, w_src_dsr};
    w_ge      = ~w_diff[WIDTH];
    // Remainder stays below the divisor, so WIDTH bits always suffice.
    w_nrem    = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_nquo    = {w_src_quo[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dsr <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= w_nrem;
      r_quo <= w_nquo;
      r_dsr <= i_divisor;
      r_cnt <= CW'(WIDTH - 1);
    end else if (r_cnt != '0) begin
      r_rem <= w_nrem;
      r_quo <= w_nquo;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == CW'(1));
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with architectural HI/LO.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start, op      one-cycle request; accepted only while not busy
//   a, b           rs / rt operands (a is the data for MTHI/MTLO)
//   busy           operation in flight, further starts ignored
//   done           one-cycle completion pulse, HI/LO already updated
//   div_by_zero    sticky, cleared by reset or the next accepted start
//   hi, lo         HI/LO registers
// States:
//   S_IDLE | waiting for start; MTHI/MTLO/illegal/div-by-zero finish here
//   S_MUL  | product travelling down the MUL_LAT delay chain
//   S_DIV  | divider iterating on magnitudes
//   S_FIX  | sign correction of quotient/remainder, then write HI/LO
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  state_e             r_state;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz;
  logic               r_q_neg, r_r_neg;
  logic [2:0]         r_mul_cnt;
  logic [2*WIDTH-1:0] r_pipe [PD];

  logic               w_accept, w_is_mul, w_div_start, w_div_last;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;

  assign w_accept = start && (r_state == S_IDLE);
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);

  // Sign-extending to 2*WIDTH makes the truncated product the exact signed one.
  assign w_a_ext = (op == OP_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign w_b_ext = (op == OP_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_a_neg     = (op == OP_DIV) && a[WIDTH-1];
  assign w_b_neg     = (op == OP_DIV) && b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? -a : a;
  assign w_b_mag     = w_b_neg ? -b : b;
  assign w_div_start = w_accept && is_div_op(op) && (b != '0);

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_last     (w_div_last),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // MIN / -1: magnitude quotient is 2^(WIDTH-1) with no negation, giving MIN.
  assign w_quo_fix = r_q_neg ? -w_quo : w_quo;
  assign w_rem_fix = r_r_neg ? -w_rem : w_rem;

  // Product delay chain; only meaningful while in S_MUL, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_mul) r_pipe[0] <= w_prod;
    for (int k = 1; k < PD; k++) r_pipe[k] <= r_pipe[k-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_mul_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dbz <= 1'b0;
            case (op)
              OP_MULT, OP_MULTU: begin
                if (MUL_LAT == 1) begin
                  {r_hi, r_lo} <= w_prod;
                  r_done       <= 1'b1;
                end else begin
                  r_mul_cnt <= 3'(MUL_LAT - 2);
                  r_state   <= S_MUL;
                end
              end
              OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                  r_dbz  <= 1'b1;
                  r_done <= 1'b1;
                end else begin
                  r_q_neg <= w_a_neg ^ w_b_neg;
                  r_r_neg <= w_a_neg;
                  r_state <= S_DIV;
                end
              end
              OP_MTHI: begin
                r_hi   <= a;
                r_done <= 1'b1;
              end
              OP_MTLO: begin
                r_lo   <= a;
                r_done <= 1'b1;
              end
              default: r_done <= 1'b1;
            endcase
          end
        end
        S_MUL: begin
          if (r_mul_cnt == '0) begin
            {r_hi, r_lo} <= r_pipe[PD-1];
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_mul_cnt <= r_mul_cnt - 3'd1;
          end
        end
        S_DIV: begin
          if (w_div_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_rem_fix;
          r_lo    <= w_quo_fix;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
